// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - write-back bus: ALU/memory result inputs, register-bank write port, hazard status
interface writeback_arbiter_if #(
    parameter int Index_size = 4,
    parameter int width      = 32,
    parameter int DEPTH      = 4
);
    logic                       alu_valid;
    logic [Index_size-1:0]      alu_rd;
    logic [width-1:0]           alu_wd;
    logic                       mem_valid;
    logic                       mem_ready;
    logic [Index_size-1:0]      mem_rd;
    logic [width-1:0]           mem_wd;
    logic                       WE;
    logic [Index_size-1:0]      Rd;
    logic [width-1:0]           WD;
    logic [2**Index_size-1:0]   pending_mask;
    logic [$clog2(DEPTH):0]     fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_wd, mem_valid, mem_rd, mem_wd,
        input  mem_ready, WE, Rd, WD, pending_mask, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_wd, mem_valid, mem_rd, mem_wd,
        output mem_ready, WE, Rd, WD, pending_mask, fifo_count
    );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges ALU and FIFO-buffered memory results onto one register write port
// Optional macro WB_BYPASS_EN: memory result skips an empty FIFO when the ALU is idle.
module writeback_arbiter #(
    parameter int Index_size = 4,
    parameter int width      = 32,
    parameter int DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    writeback_arbiter_if.slave   bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 2**Index_size;

    logic [Index_size-1:0] r_fifo_rd [DEPTH];
    logic [width-1:0]      r_fifo_wd [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_we;
    logic [Index_size-1:0] r_rd;
    logic [width-1:0]      r_wd;

    logic                  w_alu_go;
    logic                  w_mem_ready;
    logic                  w_push_ok;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic [NREG-1:0]       w_pending;

    // Register 0 is hard-wired, so writes to it are swallowed on both paths.
    assign w_alu_go    = bus.alu_valid && (bus.alu_rd != '0);
    assign w_mem_ready = !rst && (r_count != CW'(DEPTH));
    assign w_push_ok   = bus.mem_valid && w_mem_ready && (bus.mem_rd != '0);

`ifdef WB_BYPASS_EN
    assign w_bypass = w_push_ok && (r_count == '0) && !w_alu_go;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_push_ok && !w_bypass;
    assign w_pop  = !w_alu_go && (r_count != '0);

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PW'(i) - r_rd_ptr} < r_count)
                w_pending[r_fifo_rd[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr] <= bus.mem_rd;
            r_fifo_wd[r_wr_ptr] <= bus.mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_rd     <= '0;
            r_wd     <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            if (w_alu_go) begin
                r_we <= 1'b1;
                r_rd <= bus.alu_rd;
                r_wd <= bus.alu_wd;
            end else if (w_pop) begin
                r_we <= 1'b1;
                r_rd <= r_fifo_rd[r_rd_ptr];
                r_wd <= r_fifo_wd[r_rd_ptr];
            end else if (w_bypass) begin
                r_we <= 1'b1;
                r_rd <= bus.mem_rd;
                r_wd <= bus.mem_wd;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign bus.mem_ready    = w_mem_ready;
    assign bus.WE           = r_we;
    assign bus.Rd           = r_rd;
    assign bus.WD           = r_wd;
    assign bus.pending_mask = w_pending;
    assign bus.fifo_count   = r_count;
endmodule
